conv_window_gen: RTL

Streams 3×3 convolution windows (stride 1, padding 1) from the preprocessed int8 image held in channel_4~6 memories to the first convolution layer. Reads one image row at a time into three rotating row buffers, then emits one window per output pixel in raster order, channel 0, then 1, then 2, under a valid/ready handshake. Sits directly downstream of the image preprocessing stage and upstream of the conv1 MAC array.

---
 rtl/conv_window_gen.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
// conv_window_gen : streams 3x3 stride-1 pad-1 int8 windows over 3 channels
// Revision        : 1.0
// ============================================================================
module conv_window_gen #(
    parameter int               IMG_W   = 128,
    parameter int               IMG_H   = 128,
    parameter logic signed [7:0] PAD_VAL = 8'sd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        mem_rd_en,
    output logic [13:0] mem_addr,
    output logic [1:0]  mem_ch,
    input  logic [7:0]  mem_rdata,
    output logic        win_valid,
    input  logic        win_ready,
    output logic [71:0] win_data,
    output logic [6:0]  win_row,
    output logic [6:0]  win_col,
    output logic [1:0]  win_ch,
    output logic        busy,
    output logic        done
);

    localparam int CW = $clog2(IMG_W + 1);
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] c_last_col = CW'(IMG_W - 1);
    localparam logic [CW-1:0] c_drain    = CW'(IMG_W);
    localparam logic [RW-1:0] c_last_row = RW'(IMG_H - 1);
    localparam logic [RW-1:0] c_pen_row  = RW'(IMG_H - 2);
    localparam logic [7:0]    c_pad      = PAD_VAL;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_fill = 2'd1;
    localparam logic [1:0] c_st_emit = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [1:0]    ch_q, ch_d;
    logic [RW-1:0] fill_row_q, fill_row_d;
    logic [RW-1:0] emit_row_q, emit_row_d;
    logic [CW-1:0] col_q, col_d;
    logic [1:0]    fill_slot_q, fill_slot_d;
    logic [1:0]    emit_slot_q, emit_slot_d;
    logic          cap_en_q;
    logic [AW-1:0] cap_col_q;
    logic [7:0]    buf_q [3][IMG_W];

    logic [1:0]    w_rslot [3];
    logic          w_rpad  [3];
    logic [AW-1:0] w_cidx  [3];
    logic          w_cpad  [3];
    logic [71:0]   w_taps;

    function automatic logic [1:0] inc3(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    function automatic logic [1:0] dec3(input logic [1:0] s);
        return (s == 2'd0) ? 2'd2 : s - 2'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= c_st_idle;
            ch_q        <= 2'd0;
            fill_row_q  <= '0;
            emit_row_q  <= '0;
            col_q       <= '0;
            fill_slot_q <= 2'd0;
            emit_slot_q <= 2'd0;
            cap_en_q    <= 1'b0;
            cap_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            fill_row_q  <= fill_row_d;
            emit_row_q  <= emit_row_d;
            col_q       <= col_d;
            fill_slot_q <= fill_slot_d;
            emit_slot_q <= emit_slot_d;
            cap_en_q    <= mem_rd_en;
            cap_col_q   <= col_q[AW-1:0];
        end
    end

    // Row r always lives in buffer (r mod 3); read data lands one cycle after its request.
    always_ff @(posedge clk) begin
        if (cap_en_q) begin
            buf_q[fill_slot_q][cap_col_q] <= mem_rdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        fill_row_d  = fill_row_q;
        emit_row_d  = emit_row_q;
        col_d       = col_q;
        fill_slot_d = fill_slot_q;
        emit_slot_d = emit_slot_q;
        unique case (state_q)
            c_st_idle, c_st_done: begin
                if (start) begin
                    state_d     = c_st_fill;
                    ch_d        = 2'd0;
                    fill_row_d  = '0;
                    emit_row_d  = '0;
                    col_d       = '0;
                    fill_slot_d = 2'd0;
                    emit_slot_d = 2'd0;
                end
            end
            c_st_fill: begin
                if (col_q != c_drain) begin
                    col_d = col_q + 1'b1;
                end else begin
                    col_d = '0;
                    if (fill_row_q == '0) begin
                        fill_row_d  = RW'(1);
                        fill_slot_d = 2'd1;
                    end else begin
                        state_d = c_st_emit;
                    end
                end
            end
            c_st_emit: begin
                if (win_ready) begin
                    if (col_q != c_last_col) begin
                        col_d = col_q + 1'b1;
                    end else begin
                        col_d = '0;
                        if (emit_row_q == c_last_row) begin
                            if (ch_q == 2'd2) begin
                                state_d = c_st_done;
                            end else begin
                                state_d     = c_st_fill;
                                ch_d        = ch_q + 2'd1;
                                fill_row_d  = '0;
                                emit_row_d  = '0;
                                fill_slot_d = 2'd0;
                                emit_slot_d = 2'd0;
                            end
                        end else begin
                            emit_row_d  = emit_row_q + 1'b1;
                            emit_slot_d = inc3(emit_slot_q);
                            // The next-to-last row already has its lower neighbour buffered.
                            if (emit_row_q != c_pen_row) begin
                                state_d     = c_st_fill;
                                fill_row_d  = emit_row_q + RW'(2);
                                fill_slot_d = dec3(emit_slot_q);
                            end
                        end
                    end
                end
            end
            default: state_d = c_st_idle;
        endcase
    end

    always_comb begin
        w_rslot[0] = dec3(emit_slot_q);
        w_rslot[1] = emit_slot_q;
        w_rslot[2] = inc3(emit_slot_q);
        w_rpad[0]  = (emit_row_q == '0);
        w_rpad[1]  = 1'b0;
        w_rpad[2]  = (emit_row_q == c_last_row);
        w_cidx[0]  = AW'(col_q - 1'b1);
        w_cidx[1]  = AW'(col_q);
        w_cidx[2]  = AW'(col_q + 1'b1);
        w_cpad[0]  = (col_q == '0);
        w_cpad[1]  = 1'b0;
        w_cpad[2]  = (col_q == c_last_col);
        w_taps     = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w_taps[8*(3*i+j) +: 8] = (w_rpad[i] || w_cpad[j]) ? c_pad
                                       : buf_q[w_rslot[i]][w_cidx[j]];
            end
        end
    end

    always_comb begin
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        mem_ch    = 2'd0;
        win_valid = 1'b0;
        win_data  = '0;
        win_row   = '0;
        win_col   = '0;
        win_ch    = 2'd0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            c_st_fill: begin
                busy = 1'b1;
                if (col_q != c_drain) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = 14'(fill_row_q) * 14'(IMG_W) + 14'(col_q);
                    mem_ch    = ch_q;
                end
            end
            c_st_emit: begin
                busy      = 1'b1;
                win_valid = 1'b1;
                win_data  = w_taps;
                win_row   = 7'(emit_row_q);
                win_col   = 7'(col_q);
                win_ch    = ch_q;
            end
            c_st_done: done = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire
